// File: rtl/fir_output_decimator.sv
// Output stage behind fir_filter: round/saturate to OUT_W, keep every DECIM-th sample,
// and buffer kept samples in a show-ahead FIFO with a valid/ready output port.
module fir_output_decimator #(
    parameter int IN_W  = 17,
    parameter int OUT_W = 16,
    parameter int SHIFT = 0,
    parameter int DECIM = 4,
    parameter int DEPTH = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    input  logic signed [IN_W-1:0]         input_signal,
    output logic signed [OUT_W-1:0]        out_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [$clog2(DEPTH+1)-1:0]     level,
    output logic                           overflow
);

    localparam int LW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [PW-1:0] PHASE_LAST = PW'(DECIM - 1);
    localparam int RND_I = (SHIFT > 0) ? (1 << ((SHIFT > 0) ? (SHIFT - 1) : 0)) : 0;
    localparam logic signed [IN_W:0] RND     = (IN_W + 1)'(RND_I);
    localparam logic signed [IN_W:0] SAT_MAX = (IN_W + 1)'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [IN_W:0] SAT_MIN = ~SAT_MAX;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    // Clamp a widened value into the signed OUT_W range.
    function automatic logic signed [OUT_W-1:0] saturate(input logic signed [IN_W:0] v);
        logic signed [OUT_W-1:0] r;
        if (v > SAT_MAX) begin
            r = {1'b0, {(OUT_W-1){1'b1}}};
        end else if (v < SAT_MIN) begin
            r = {1'b1, {(OUT_W-1){1'b0}}};
        end else begin
            r = v[OUT_W-1:0];
        end
        return r;
    endfunction

    logic [PW-1:0]            phase_r;
    logic [PW-1:0]            phase_nxt_s;
    logic                     keep_s;
    logic signed [IN_W:0]     ext_s;
    logic signed [IN_W:0]     sum_s;
    logic signed [IN_W:0]     shifted_s;
    logic                     s1_valid_r;
    logic signed [OUT_W-1:0]  s1_data_r;
    logic signed [OUT_W-1:0]  mem_r [DEPTH];
    logic [AW-1:0]            wr_ptr_r;
    logic [AW-1:0]            rd_ptr_r;
    logic [AW-1:0]            rd_ptr_nxt_s;
    logic [LW-1:0]            level_r;
    logic [LW-1:0]            level_nxt_s;
    logic                     overflow_r;
    logic signed [OUT_W-1:0]  out_data_r;
    logic signed [OUT_W-1:0]  head_nxt_s;
    logic                     out_valid_r;
    logic                     pop_s;
    logic                     push_s;
    logic                     full_s;
    logic                     drop_s;

    // Decimation phase and keep decision; the extra bit in ext_s absorbs the rounding carry.
    always_comb begin
        keep_s    = in_valid && (phase_r == {PW{1'b0}});
        ext_s     = {input_signal[IN_W-1], input_signal};
        sum_s     = ext_s + RND;
        shifted_s = sum_s >>> SHIFT;
        if (in_valid) begin
            if (phase_r == PHASE_LAST) begin
                phase_nxt_s = {PW{1'b0}};
            end else begin
                phase_nxt_s = phase_r + PW'(1);
            end
        end else begin
            phase_nxt_s = phase_r;
        end
    end

    // Phase counter and stage-1 round/saturate register.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_r    <= {PW{1'b0}};
            s1_valid_r <= 1'b0;
            s1_data_r  <= {OUT_W{1'b0}};
        end else begin
            phase_r    <= phase_nxt_s;
            s1_valid_r <= keep_s;
            if (keep_s) begin
                s1_data_r <= saturate(shifted_s);
            end else begin
                s1_data_r <= s1_data_r;
            end
        end
    end

    // FIFO control; the next head is precomputed so out_data comes straight from a flop.
    always_comb begin
        pop_s  = out_valid_r && out_ready;
        full_s = (level_r == FULL_LVL);
        push_s = s1_valid_r && (!full_s || pop_s);
        drop_s = s1_valid_r && full_s && !pop_s;
        case ({push_s, pop_s})
            2'b10:   level_nxt_s = level_r + LW'(1);
            2'b01:   level_nxt_s = level_r - LW'(1);
            default: level_nxt_s = level_r;
        endcase
        if (pop_s) begin
            rd_ptr_nxt_s = rd_ptr_r + AW'(1);
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end
        if (level_nxt_s == {LW{1'b0}}) begin
            head_nxt_s = out_data_r;
        end else if (push_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
            head_nxt_s = s1_data_r;
        end else begin
            head_nxt_s = mem_r[rd_ptr_nxt_s];
        end
    end

    // FIFO storage; contents need no reset since the pointers define validity.
    always_ff @(posedge clk) begin
        if (push_s && !rst) begin
            mem_r[wr_ptr_r] <= s1_data_r;
        end
    end

    // FIFO pointers, occupancy, registered head and sticky overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r    <= {AW{1'b0}};
            rd_ptr_r    <= {AW{1'b0}};
            level_r     <= {LW{1'b0}};
            overflow_r  <= 1'b0;
            out_data_r  <= {OUT_W{1'b0}};
            out_valid_r <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            rd_ptr_r    <= rd_ptr_nxt_s;
            level_r     <= level_nxt_s;
            overflow_r  <= overflow_r || drop_s;
            out_data_r  <= head_nxt_s;
            out_valid_r <= (level_nxt_s != {LW{1'b0}});
        end
    end

    assign out_data  = out_data_r;
    assign out_valid = out_valid_r;
    assign level     = level_r;
    assign overflow  = overflow_r;

endmodule

// File: tb/tb_fir_output_decimator.sv
// Scoreboard bench for fir_output_decimator: two parameterisations share one stimulus
// stream; a queue-based reference model predicts per-edge state and accepted samples.
module tb_fir_output_decimator;

    localparam int DEC0 = 4, SH0 = 0, DEP0 = 8;
    localparam int DEC1 = 1, SH1 = 1, DEP1 = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst;
    logic                in_valid;
    logic                out_ready;
    logic signed [16:0]  input_signal;
    logic signed [15:0]  od0, od1;
    logic                ov0, ov1, of0, of1;
    logic [3:0]          lv0;
    logic [2:0]          lv1;

    fir_output_decimator #(.IN_W(17), .OUT_W(16), .SHIFT(SH0), .DECIM(DEC0), .DEPTH(DEP0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .input_signal(input_signal),
        .out_data(od0), .out_valid(ov0), .out_ready(out_ready), .level(lv0), .overflow(of0)
    );

    fir_output_decimator #(.IN_W(17), .OUT_W(16), .SHIFT(SH1), .DECIM(DEC1), .DEPTH(DEP1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .input_signal(input_signal),
        .out_data(od1), .out_valid(ov1), .out_ready(out_ready), .level(lv1), .overflow(of1)
    );

    typedef struct {int edge_no; int lvl; bit ovf; bit was_rst; int gen;} st_t;
    typedef struct {int val; int gen;} dat_t;

    st_t  st_q  [2][$];
    dat_t exp_q [2][$];
    int   m_level [2];
    int   m_vcount[2];
    int   m_s1d   [2];
    int   m_gen   [2];
    bit   m_ovf   [2];
    bit   m_s1v   [2];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int dec_of(input int i);
        return (i == 0) ? DEC0 : DEC1;
    endfunction

    function automatic int dep_of(input int i);
        return (i == 0) ? DEP0 : DEP1;
    endfunction

    function automatic int sh_of(input int i);
        return (i == 0) ? SH0 : SH1;
    endfunction

    // Round half up by 2^sh, then clamp to 16-bit signed.
    function automatic int refconv(input int x, input int sh);
        int t;
        if (sh > 0) t = (x + (1 << (sh - 1))) >>> sh;
        else        t = x;
        if (t > 32767)  t = 32767;
        if (t < -32768) t = -32768;
        return t;
    endfunction

    task automatic chk(input int i, input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL inst%0d %s at cycle %0d: got %0d expected %0d", i, name, cyc, act, exp);
        end
    endtask

    // Reference model: what instance i looks like after the coming clock edge.
    task automatic model_edge(input int i, input bit r, input bit v, input int x, input bit rdy);
        st_t  s;
        dat_t d;
        bit   pop;
        bit   acc;
        if (r) begin
            m_gen[i]++;
            m_level[i]  = 0;
            m_ovf[i]    = 1'b0;
            m_s1v[i]    = 1'b0;
            m_vcount[i] = 0;
        end else begin
            pop = (m_level[i] > 0) && rdy;
            acc = 1'b0;
            if (m_s1v[i]) begin
                if ((m_level[i] < dep_of(i)) || pop) begin
                    acc   = 1'b1;
                    d.val = m_s1d[i];
                    d.gen = m_gen[i];
                    exp_q[i].push_back(d);
                end else begin
                    m_ovf[i] = 1'b1;
                end
            end
            m_level[i] = m_level[i] + int'(acc) - int'(pop);
            m_s1v[i]   = v && ((m_vcount[i] % dec_of(i)) == 0);
            if (v) begin
                m_s1d[i] = refconv(x, sh_of(i));
                m_vcount[i]++;
            end
        end
        s.edge_no = cyc + 1;
        s.lvl     = m_level[i];
        s.ovf     = m_ovf[i];
        s.was_rst = r;
        s.gen     = m_gen[i];
        st_q[i].push_back(s);
    endtask

    task automatic cycle(input bit r, input bit v, input int x, input bit rdy);
        @(posedge clk);
        #2;
        rst          = r;
        in_valid     = v;
        input_signal = x[16:0];
        out_ready    = rdy;
        model_edge(0, r, v, x, rdy);
        model_edge(1, r, v, x, rdy);
    endtask

    task automatic check_inst(input int i);
        st_t  s;
        dat_t d;
        int   lvl, dv;
        bit   vld, ofl;
        if (st_q[i].size() == 0) return;
        if (st_q[i][0].edge_no != cyc) return;
        s   = st_q[i].pop_front();
        lvl = (i == 0) ? int'(lv0) : int'(lv1);
        dv  = (i == 0) ? int'(od0) : int'(od1);
        vld = (i == 0) ? ov0 : ov1;
        ofl = (i == 0) ? of0 : of1;
        chk(i, "level", lvl, s.lvl);
        chk(i, "overflow", int'(ofl), int'(s.ovf));
        chk(i, "out_valid", int'(vld), int'(s.lvl != 0));
        if (s.was_rst) chk(i, "out_data_after_rst", dv, 0);
        while (exp_q[i].size() != 0 && exp_q[i][0].gen < s.gen) d = exp_q[i].pop_front();
        if (s.lvl != 0) begin
            if (exp_q[i].size() == 0) begin
                chk(i, "expected_queue_empty", 0, 1);
            end else begin
                chk(i, "out_data", dv, exp_q[i][0].val);
                if (out_ready) d = exp_q[i].pop_front();
            end
        end
    endtask

    // Monitor: compare each instance against its prediction for the edge just taken.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) check_inst(i);
    end

    int sat_vals[10] = '{40000, -40000, 32767, -32768, -1, 3, -3, 2, 65535, -65536};
    bit gap_v[7]     = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    int gap_x[7]     = '{10, 99, 99, 11, 12, 99, 13};

    initial begin
        rst          = 1'b1;
        in_valid     = 1'b0;
        out_ready    = 1'b0;
        input_signal = 17'sd0;
        repeat (3) cycle(1'b1, 1'b0, 0, 1'b0);
        // Decimation of a ramp with a free-running consumer.
        for (int k = 0; k < 16; k++) cycle(1'b0, 1'b1, k, 1'b1);
        // Saturation and rounding corners, each held for a full decimation period.
        for (int k = 0; k < 10; k++) repeat (4) cycle(1'b0, 1'b1, sat_vals[k], 1'b1);
        repeat (3) cycle(1'b0, 1'b0, 0, 1'b1);
        // Idle gaps must not advance the phase.
        for (int k = 0; k < 7; k++) cycle(1'b0, gap_v[k], gap_x[k], 1'b1);
        // Stalled consumer: fill, overflow, then drain.
        for (int k = 0; k < 40; k++) cycle(1'b0, 1'b1, k, 1'b0);
        repeat (4) cycle(1'b0, 1'b0, 0, 1'b0);
        repeat (12) cycle(1'b0, 1'b0, 0, 1'b1);
        // Fill to exactly full, then pop only when a push lands, then reset mid-stream.
        cycle(1'b1, 1'b0, 0, 1'b0);
        for (int k = 0; k < 32; k++) cycle(1'b0, 1'b1, 100 + k, 1'b0);
        repeat (3) cycle(1'b0, 1'b0, 0, 1'b0);
        for (int k = 0; k < 12; k++) cycle(1'b0, 1'b1, 200 + k, (k % 4) == 1);
        cycle(1'b1, 1'b1, 555, 1'b1);
        cycle(1'b0, 1'b1, 777, 1'b1);
        repeat (4) cycle(1'b0, 1'b1, -777, 1'b1);
        // Random traffic with stalls and occasional resets.
        for (int k = 0; k < 400; k++) begin
            cycle($urandom_range(0, 99) == 0,
                  $urandom_range(0, 3) != 0,
                  int'($urandom_range(0, 131070)) - 65535,
                  ((k / 32) % 3 == 2) ? 1'b0 : ($urandom_range(0, 3) != 0));
        end
        repeat (20) cycle(1'b0, 1'b0, 0, 1'b1);
        repeat (2) @(posedge clk);
        #3;
        for (int i = 0; i < 2; i++) begin
            chk(i, "pending_state", st_q[i].size(), 0);
            chk(i, "pending_data", exp_q[i].size(), 0);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
